column_reader: RTL and testbench

- Bottom-of-column readout controller that drives one 16-pixel column chain from below.
- Forwards the broadcast bus (reset, L1A, L1 address) up the column.
- After each L1A, samples the column hit count, then pulses the read strobe once per hit to pull 46-bit pixel words down the chain.
- Emits a header word plus the data words per event on a valid/ready stream toward the frame builder.

---
 rtl/column_reader.sv | 213 +++++++++++++++++++++
 tb/tb_column_reader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/column_reader.sv
// Readout controller at the bottom of one pixel column. It forwards the broadcast bus,
// queues L1A triggers and drains each event as a header plus one word per hit.
module column_reader #(
    parameter int L1ADDRWIDTH = 7,
    parameter int BCSTWIDTH   = 27,
    parameter int HITLAT      = 4
) (
    input  logic                 clkRO,
    input  logic                 reset,
    input  logic [3:0]           colAddrIn,
    input  logic [BCSTWIDTH-1:0] bcstIn,
    output logic [BCSTWIDTH-1:0] colBCST,
    input  logic [4:0]           colHits,
    input  logic [45:0]          colData,
    output logic                 colRead,
    output logic [45:0]          outData,
    output logic                 outIsHeader,
    output logic                 outValid,
    input  logic                 outReady,
    output logic                 l1aOverflow,
    output logic                 hitOverflow
);

    localparam int QDEPTH = 4;
    // The push cycle counts as the first of the HITLAT cycles, so the head is ready
    // exactly in the cycle colHits becomes valid.
    localparam logic [3:0] CNT_INIT = 4'(HITLAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_FETCH, S_SETTLE} state_t;

    logic [BCSTWIDTH-1:0]   r_col_bcst;
    logic [L1ADDRWIDTH-1:0] r_q_addr [QDEPTH];
    logic [3:0]             r_q_cnt  [QDEPTH];
    logic [2:0]             r_q_count;
    logic                   r_l1a_ovf;

    state_t                 r_state;
    logic [4:0]             r_remaining;
    logic [45:0]            r_out_data;
    logic                   r_out_is_header;
    logic                   r_out_valid;
    logic                   r_col_read;
    logic                   r_hit_ovf;

    logic                   w_col_reset;
    logic                   w_l1a;
    logic [L1ADDRWIDTH-1:0] w_l1_addr;
    logic                   w_head_ready;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_full;
    logic                   w_push_ok;
    logic                   w_l1a_drop;
    logic [4:0]             w_hits_sat;
    logic [45:0]            w_header;
    logic [L1ADDRWIDTH-1:0] w_q_addr_nxt [QDEPTH];
    logic [3:0]             w_q_cnt_nxt  [QDEPTH];
    logic [2:0]             w_q_count_nxt;

    function automatic logic [3:0] f_dec(input logic [3:0] v);
        return (v != 4'd0) ? v - 4'd1 : 4'd0;
    endfunction

    assign colBCST     = r_col_bcst;
    assign colRead     = r_col_read;
    assign outData     = r_out_data;
    assign outIsHeader = r_out_is_header;
    assign outValid    = r_out_valid;
    assign l1aOverflow = r_l1a_ovf;
    assign hitOverflow = r_hit_ovf;

    assign w_col_reset  = r_col_bcst[0];
    assign w_l1a        = r_col_bcst[1];
    assign w_l1_addr    = r_col_bcst[L1ADDRWIDTH+1:2];
    assign w_head_ready = (r_q_count != 3'd0) && (r_q_cnt[0] == 4'd0);
    assign w_pop        = (r_state == S_IDLE) && w_head_ready && !w_col_reset;
    assign w_push       = w_l1a && !w_col_reset;
    assign w_full       = (r_q_count == 3'(QDEPTH));
    assign w_push_ok    = w_push && (!w_full || w_pop);
    assign w_l1a_drop   = w_push && w_full && !w_pop;
    assign w_hits_sat   = (colHits > 5'd16) ? 5'd16 : colHits;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_header                     = '0;
        w_header[3:0]                = colAddrIn;
        w_header[8:4]                = w_hits_sat;
        w_header[8+L1ADDRWIDTH:9]    = r_q_addr[0];
    end

    // Next queue image: age all entries, shift out the head on pop, append at the tail on push.
    always_comb begin
        w_q_count_nxt = r_q_count;
        for (int i = 0; i < QDEPTH; i++) begin
            w_q_addr_nxt[i] = r_q_addr[i];
            w_q_cnt_nxt[i]  = f_dec(r_q_cnt[i]);
        end
        if (w_pop) begin
            for (int i = 0; i < QDEPTH - 1; i++) begin
                w_q_addr_nxt[i] = r_q_addr[i+1];
                w_q_cnt_nxt[i]  = f_dec(r_q_cnt[i+1]);
            end
            w_q_count_nxt = r_q_count - 3'd1;
        end
        if (w_push_ok) begin
            w_q_addr_nxt[w_q_count_nxt[1:0]] = w_l1_addr;
            w_q_cnt_nxt[w_q_count_nxt[1:0]]  = CNT_INIT;
            w_q_count_nxt                    = w_q_count_nxt + 3'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clkRO or posedge reset) begin
        if (reset) begin
            r_col_bcst <= '0;
        end else begin
            r_col_bcst <= bcstIn;
        end
    end

    always_ff @(posedge clkRO or posedge reset) begin
        if (reset) begin
            // NOTE: the queue is four entries of plain flops, cheap enough to clear on reset like any other state.
            for (int i = 0; i < QDEPTH; i++) begin
                r_q_addr[i] <= '0;
                r_q_cnt[i]  <= '0;
            end
            r_q_count <= '0;
            r_l1a_ovf <= 1'b0;
        end else if (w_col_reset) begin
            r_q_count <= '0;
            r_l1a_ovf <= 1'b0;
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                r_q_addr[i] <= w_q_addr_nxt[i];
                r_q_cnt[i]  <= w_q_cnt_nxt[i];
            end
            r_q_count <= w_q_count_nxt;
            if (w_l1a_drop) begin
                r_l1a_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clkRO or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_remaining     <= '0;
            r_out_data      <= '0;
            r_out_is_header <= 1'b0;
            r_out_valid     <= 1'b0;
            r_col_read      <= 1'b0;
            r_hit_ovf       <= 1'b0;
        end else if (w_col_reset) begin
            r_state         <= S_IDLE;
            r_remaining     <= '0;
            r_out_data      <= '0;
            r_out_is_header <= 1'b0;
            r_out_valid     <= 1'b0;
            r_col_read      <= 1'b0;
            r_hit_ovf       <= 1'b0;
        end else begin
            r_col_read <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_head_ready) begin
                        r_remaining     <= w_hits_sat;
                        r_out_data      <= w_header;
                        r_out_is_header <= 1'b1;
                        r_out_valid     <= 1'b1;
                        r_state         <= S_HEADER;
                        if (colHits > 5'd16) begin
                            r_hit_ovf <= 1'b1;
                        end
                    end
                end
                S_HEADER: begin
                    if (r_out_valid && outReady) begin
                        r_out_valid <= 1'b0;
                        if (r_remaining == 5'd0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_col_read <= 1'b1;
                            r_state    <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    // FETCH is only entered after the previous word was accepted, so the
                    // output register is always free here and the read strobe is high.
                    r_out_data      <= colData;
                    r_out_is_header <= 1'b0;
                    r_out_valid     <= 1'b1;
                    r_remaining     <= r_remaining - 5'd1;
                    r_state         <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (!r_out_valid || outReady) begin
                        r_out_valid <= 1'b0;
                        if (r_remaining != 5'd0) begin
                            r_col_read <= 1'b1;
                            r_state    <= S_FETCH;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_column_reader.sv
// Directed bench for column_reader: a behavioural column supplies numbered pixel words,
// a monitor logs stream transfers and read strobes, expected words are built locally.
module tb_column_reader;

    localparam int BW = 27;

    logic          clkRO = 1'b0;
    logic          reset;
    logic [3:0]    colAddrIn;
    logic [BW-1:0] bcstIn;
    logic [BW-1:0] colBCST;
    logic [4:0]    colHits;
    logic [45:0]   colData;
    logic          colRead;
    logic [45:0]   outData;
    logic          outIsHeader;
    logic          outValid;
    logic          outReady;
    logic          l1aOverflow;
    logic          hitOverflow;

    column_reader #(.L1ADDRWIDTH(7), .BCSTWIDTH(BW), .HITLAT(4)) u_dut (
        .clkRO       (clkRO),
        .reset       (reset),
        .colAddrIn   (colAddrIn),
        .bcstIn      (bcstIn),
        .colBCST     (colBCST),
        .colHits     (colHits),
        .colData     (colData),
        .colRead     (colRead),
        .outData     (outData),
        .outIsHeader (outIsHeader),
        .outValid    (outValid),
        .outReady    (outReady),
        .l1aOverflow (l1aOverflow),
        .hitOverflow (hitOverflow)
    );

    always #5 clkRO = ~clkRO;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [45:0] pix_word(input int k);
        return {6'h2A, 8'(k), 32'(k * 32'h0001_0101 + 7)};
    endfunction

    function automatic logic [63:0] hdr(input int addr, input int hits);
        return 64'({1'b1, 30'd0, 7'(addr), 5'(hits), 4'hA});
    endfunction

    function automatic logic [63:0] dat(input int k);
        return 64'({1'b0, pix_word(k)});
    endfunction

    // Column model: the oldest pending word shifts out on each read strobe.
    int ptr = 0;
    assign colData = pix_word(ptr);
    always @(posedge clkRO) if (colRead) ptr <= ptr + 1;

    // Monitor samples mid-cycle, after the bench has driven its inputs.
    int          cyc = 0;
    int          n_reads = 0;
    int          n_b2b = 0;
    logic        prev_read = 1'b0;
    int          read_cyc [256];
    logic [46:0] rx_mem [256];
    int          rx_n = 0;

    initial forever begin
        @(negedge clkRO);
        #3;
        cyc++;
        if (colRead) begin
            read_cyc[n_reads & 255] = cyc;
            if (prev_read) n_b2b++;
            n_reads++;
        end
        prev_read = colRead;
        if (outValid && outReady) begin
            rx_mem[rx_n & 255] = {outIsHeader, outData};
            rx_n++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clkRO);
    endtask

    task automatic send_l1a(input int addr, input logic [4:0] hits);
        colHits = hits;
        bcstIn  = BW'((addr << 2) | 2);
        tick();
        bcstIn  = '0;
    endtask

    task automatic wait_words(input string tag, input int base, input int n);
        int c = 0;
        while (rx_n - base < n && c < 400) begin
            tick();
            c++;
        end
        tick(6);
        check(tag, 64'(rx_n - base), 64'(n));
    endtask

    function automatic logic [63:0] rx(input int idx);
        return 64'(rx_mem[idx & 255]);
    endfunction

    // L1A addr 5 with 3 hits, outReady held high.
    task automatic run_basic(input string tag);
        int base = rx_n;
        int p0   = ptr;
        int r0   = n_reads;
        colHits = 5'd3;
        bcstIn  = BW'(27'h16);
        #1 check({tag, "_bcst_pre"}, 64'(colBCST), 64'h0);
        tick();
        check({tag, "_bcst_copy"}, 64'(colBCST), 64'h16);
        bcstIn = '0;
        wait_words({tag, "_words"}, base, 4);
        check({tag, "_hdr"}, rx(base), hdr(5, 3));
        for (int k = 0; k < 3; k++) check({tag, "_data"}, rx(base + 1 + k), dat(p0 + k));
        check({tag, "_reads"}, 64'(n_reads - r0), 64'd3);
        check({tag, "_gap01"}, 64'(read_cyc[(r0 + 1) & 255] - read_cyc[r0 & 255]), 64'd2);
        check({tag, "_gap12"}, 64'(read_cyc[(r0 + 2) & 255] - read_cyc[(r0 + 1) & 255]), 64'd2);
        check({tag, "_idle_valid"}, 64'(outValid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, p0, r0, c, bad;
        reset     = 1'b1;
        bcstIn    = '0;
        colHits   = '0;
        outReady  = 1'b1;
        colAddrIn = 4'hA;
        tick(3);
        check("rst_bcst", 64'(colBCST), 64'h0);
        check("rst_outputs", 64'({colRead, outData, outIsHeader, outValid}), 64'h0);
        check("rst_flags", 64'({l1aOverflow, hitOverflow}), 64'h0);
        reset = 1'b0;
        tick(2);

        run_basic("s1");

        // Zero-hit event: header only.
        base = rx_n; r0 = n_reads;
        send_l1a(7'h7F, 5'd0);
        wait_words("s2_words", base, 1);
        check("s2_hdr", rx(base), hdr(7'h7F, 0));
        check("s2_reads", 64'(n_reads - r0), 64'd0);
        check("s2_valid", 64'(outValid), 64'd0);

        // Backpressure for 10 cycles on the first data word.
        base = rx_n; p0 = ptr; r0 = n_reads;
        send_l1a(7'h33, 5'd3);
        c = 0;
        while (!(outValid && !outIsHeader) && c < 50) begin
            tick();
            c++;
        end
        check("s3_reach_data", 64'(outValid & ~outIsHeader), 64'd1);
        outReady = 1'b0;
        bad = 0;
        repeat (10) begin
            tick();
            if (outData !== pix_word(p0) || !outValid || outIsHeader) bad++;
        end
        check("s3_stall_hold", 64'(bad), 64'd0);
        check("s3_stall_reads", 64'(n_reads - r0), 64'd1);
        outReady = 1'b1;
        wait_words("s3_words", base, 4);
        check("s3_hdr", rx(base), hdr(7'h33, 3));
        for (int k = 0; k < 3; k++) check("s3_data", rx(base + 1 + k), dat(p0 + k));
        check("s3_reads", 64'(n_reads - r0), 64'd3);

        // Five L1As during a 16-hit event: four queued, the fifth dropped.
        base = rx_n; p0 = ptr; r0 = n_reads;
        send_l1a(7'h10, 5'd16);
        tick(8);
        colHits = 5'd1;
        for (int j = 0; j < 5; j++) begin
            bcstIn = BW'(((7'h21 + j) << 2) | 2);
            tick();
        end
        bcstIn = '0;
        tick(2);
        check("s4_l1a_ovf", 64'(l1aOverflow), 64'd1);
        wait_words("s4_words", base, 25);
        check("s4_hdr0", rx(base), hdr(7'h10, 16));
        for (int k = 0; k < 16; k++) check("s4_data0", rx(base + 1 + k), dat(p0 + k));
        for (int j = 0; j < 4; j++) begin
            check("s4_hdrq", rx(base + 17 + 2 * j), hdr(7'h21 + j, 1));
            check("s4_dataq", rx(base + 18 + 2 * j), dat(p0 + 16 + j));
        end
        check("s4_reads", 64'(n_reads - r0), 64'd20);
        check("s4_hit_ovf", 64'(hitOverflow), 64'd0);

        // colHits above 16 saturates to 16 and flags it.
        base = rx_n; p0 = ptr; r0 = n_reads;
        send_l1a(7'h44, 5'd20);
        wait_words("s5_words", base, 17);
        check("s5_hit_ovf", 64'(hitOverflow), 64'd1);
        check("s5_hdr", rx(base), hdr(7'h44, 16));
        check("s5_first", rx(base + 1), dat(p0));
        check("s5_last", rx(base + 16), dat(p0 + 15));
        check("s5_reads", 64'(n_reads - r0), 64'd16);

        // Column reset with an L1A on the same word, mid-event.
        r0 = n_reads;
        send_l1a(7'h55, 5'd8);
        c = 0;
        while (n_reads - r0 < 2 && c < 100) begin
            tick();
            c++;
        end
        check("s6_reach_data", 64'(n_reads - r0 >= 2), 64'd1);
        bcstIn = BW'((7'h66 << 2) | 3);
        tick();
        bcstIn = '0;
        tick();
        check("s6_colread", 64'(colRead), 64'd0);
        check("s6_valid", 64'(outValid), 64'd0);
        check("s6_flags", 64'({l1aOverflow, hitOverflow}), 64'h0);
        base = rx_n; r0 = n_reads;
        tick(20);
        check("s6_no_words", 64'(rx_n - base), 64'd0);
        check("s6_no_reads", 64'(n_reads - r0), 64'd0);
        run_basic("s6b");

        // Asynchronous reset while the read strobe is high.
        send_l1a(7'h12, 5'd20);
        c = 0;
        while (!colRead && c < 50) begin
            tick();
            c++;
        end
        check("s7_reach_fetch", 64'(colRead), 64'd1);
        check("s7_pre_hit_ovf", 64'(hitOverflow), 64'd1);
        reset = 1'b1;
        #1;
        check("s7_colread", 64'(colRead), 64'd0);
        check("s7_valid", 64'(outValid), 64'd0);
        check("s7_flags", 64'({l1aOverflow, hitOverflow}), 64'h0);
        tick();
        reset = 1'b0;
        base = rx_n; r0 = n_reads;
        tick(20);
        check("s7_no_words", 64'(rx_n - base), 64'd0);
        check("s7_no_reads", 64'(n_reads - r0), 64'd0);
        run_basic("s7b");

        check("no_b2b_reads", 64'(n_b2b), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
